pll_phase_ctrl: RTL
===================

# pll_phase_ctrl

Sequencer that drives the dynamic phase-adjust and power-down pins of a PolarFire CCC/PLL (`PHASE_OUTx_SEL`, `PHASE_DIRECTION`, `PHASE_ROTATE`, `LOAD_PHASE_N`, `PLL_POWERDOWN_N`) for up to four outputs.
- Powers the PLL up after reset and qualifies lock.
- Accepts multi-step phase-shift requests over a valid/ready handshake.
- Tracks the current phase position of each output, modulo one output period.
- Sits beside the DDR3 CCC wrapper and serves training logic that needs per-output phase rotation.

## Interface
Parameters:
- `NUM_OUT`, 4, number of PLL outputs controlled (1–4)
- `PHASE_MOD`, 32, rotate steps per full output period; `PHASE_CNT_W` = clog2(`PHASE_MOD`)
- `PWRDN_CYC`, 16, cycles `PLL_POWERDOWN_N` is held low after reset
- `LOCK_FILTER_CYC`, 16, consecutive synced-lock-high cycles required to declare lock
- `ROT_HI_CYC`, 2, `PHASE_ROTATE` high cycles per step
- `ROT_LO_CYC`, 2, `PHASE_ROTATE` low cycles per step
- `SETTLE_CYC`, 4, wait cycles after the load pulse

Ports:
- `CLK` in 1 — single clock
- `RESET_N` in 1 — asynchronous, active-low reset
- `PLL_LOCK` in 1 — raw PLL lock (asynchronous)
- `REQ_VALID` in 1 — request valid
- `REQ_READY` out 1 — request accepted when high with `REQ_VALID`
- `REQ_SEL` in `NUM_OUT` — bit mask of outputs to rotate together
- `REQ_DIR` in 1 — 1 = advance, 0 = retard
- `REQ_STEPS` in 8 — number of rotate steps, 0 allowed
- `ERR_CLR` in 1 — clears `ERR`
- `PLL_POWERDOWN_N` out 1
- `PHASE_OUT_SEL` out `NUM_OUT`
- `PHASE_DIRECTION` out 1
- `PHASE_ROTATE` out 1
- `LOAD_PHASE_N` out 1
- `PHASE_POS` out `NUM_OUT`*`PHASE_CNT_W` — output i occupies bits [i*W +: W]
- `LOCKED` out 1
- `BUSY` out 1
- `DONE` out 1 — one-cycle completion pulse
- `ERR` out 1 — sticky; set on lock loss

## Operation
- Reset values:
  - `PLL_POWERDOWN_N`=0, `PHASE_OUT_SEL`=0, `PHASE_DIRECTION`=0, `PHASE_ROTATE`=0, `LOAD_PHASE_N`=1.
  - `PHASE_POS`=0, `LOCKED`=0, `REQ_READY`=0, `BUSY`=1, `DONE`=0, `ERR`=0.
  - State = PWRDN.
- States:
  - PWRDN: hold for `PWRDN_CYC` cycles, then drive `PLL_POWERDOWN_N`=1 → WAIT_LOCK.
  - WAIT_LOCK: after `LOCK_FILTER_CYC` consecutive synced-lock-high cycles → IDLE and set `LOCKED`=1. Any low sample restarts the count.
  - IDLE: `REQ_READY`=1, `BUSY`=0. On handshake, latch sel, dir and steps.
    - steps==0 or sel==0: stay in IDLE, pulse `DONE` next cycle, no pin activity.
    - Otherwise → SETUP.
  - SETUP (1 cycle): drive `PHASE_OUT_SEL`=sel and `PHASE_DIRECTION`=dir; both are held stable until LOAD ends.
  - ROT_HI (`ROT_HI_CYC` cycles): `PHASE_ROTATE`=1.
  - ROT_LO (`ROT_LO_CYC` cycles): `PHASE_ROTATE`=0. At the exit edge, decrement the remaining count and update `PHASE_POS` of every selected output. Remaining > 0 → ROT_HI; else → LOAD.
  - LOAD (1 cycle): `LOAD_PHASE_N`=0.
  - SETTLE (`SETTLE_CYC` cycles): `PHASE_OUT_SEL` returns to 0; then → IDLE with a `DONE` pulse.
- Position arithmetic: modulo `PHASE_MOD`. Advance wraps `PHASE_MOD`-1 → 0; retard wraps 0 → `PHASE_MOD`-1. Unselected outputs are unchanged.
- Lock loss: a synced lock low in any state from IDLE onward causes, on the next edge:
  - abort the sequence; force `PHASE_ROTATE`=0, `PHASE_OUT_SEL`=0, `LOAD_PHASE_N`=1;
  - clear all `PHASE_POS` to 0; set `LOCKED`=0 and `ERR`=1;
  - go to WAIT_LOCK; no `DONE` pulse.
- `ERR_CLR` clears `ERR`. If lock loss and `ERR_CLR` occur in the same cycle, set wins.
- Asserting `RESET_N` mid-sequence returns all outputs to their reset values immediately and re-enters PWRDN.

## Timing
- `PLL_LOCK` passes through a 2-flop synchroniser: 2 cycles of latency before it reaches the filter.
- Request accepted at edge 0:
  - SETUP occupies cycle 1.
  - The first `PHASE_ROTATE` rise is at cycle 2.
  - `DONE` asserts in cycle 3 + N·(`ROT_HI_CYC`+`ROT_LO_CYC`) + `SETTLE_CYC`, the same cycle `REQ_READY` returns high.
- `REQ_READY` is low from cycle 1 until `DONE`; back-to-back requests are accepted on the `DONE` cycle.
- The `PHASE_POS` update for step k becomes visible at cycle 2 + k·(H+L).

## Structure
- Package `pll_phase_pkg` holds:
  - the state enum (PWRDN, WAIT_LOCK, IDLE, SETUP, ROT_HI, ROT_LO, LOAD, SETTLE);
  - the `REQ_STEPS` width constant (8);
  - a mod-increment/decrement function.
- Sub-module `pll_lock_filter` contains the 2-flop synchroniser and the consecutive-high counter. Its output is a qualified lock plus a one-cycle lock-loss pulse.

## Test plan
- Reset release with `PLL_LOCK` tied high → `PLL_POWERDOWN_N` rises after 16 cycles, `LOCKED` after 16+2+16 cycles.
- `REQ_SEL`=4'b0101, dir=1, steps=3, from positions 0 → 3 `PHASE_ROTATE` pulses (2 high, 2 low), one `LOAD_PHASE_N` low cycle, `DONE` at cycle 19, `PHASE_POS`[0]=3, [2]=3, others 0.
- Output 1 at position 1, retard 3 steps → wraps to 30; advance 2 from 31 → 1.
- steps=0 → `DONE` in cycle 1, no `PHASE_ROTATE`/`LOAD_PHASE_N` activity, positions unchanged.
- Drop `PLL_LOCK` during the second rotate step → `PHASE_ROTATE` forced low, `ERR`=1, `LOCKED`=0, positions 0, no `DONE`, re-lock returns to IDLE.
- `RESET_N` low during SETTLE → all outputs at reset values immediately and `PLL_POWERDOWN_N`=0.

Source files
------------

// File: rtl/pll_phase_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pll_phase_pkg
//  Description : Shared types, constants and phase arithmetic for the
//                PolarFire CCC/PLL phase-adjust sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package pll_phase_pkg;

    // Width of the rotate-step count carried by a request.
    localparam int STEPS_W = 8;

    typedef enum logic [2:0] {
        PWRDN     = 3'd0,
        WAIT_LOCK = 3'd1,
        IDLE      = 3'd2,
        SETUP     = 3'd3,
        ROT_HI    = 3'd4,
        ROT_LO    = 3'd5,
        LOAD      = 3'd6,
        SETTLE    = 3'd7
    } state_t;

    // One rotate step on a position held modulo 'modulus'.
    function automatic int phase_next(input int pos, input logic advance, input int modulus);
        if (advance) begin
            return (pos >= modulus - 1) ? 0 : pos + 1;
        end
        return (pos == 0) ? modulus - 1 : pos - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_phase_ctrl_lock_filter.sv
`default_nettype none
// ============================================================================
//  Module      : pll_lock_filter
//  Description : Two-flop synchroniser for the raw PLL lock followed by a
//                consecutive-high counter. Produces a qualified lock, a
//                one-cycle "lock acquired this edge" strobe and a one-cycle
//                lock-loss pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_filter #(
    parameter int FILTER_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic lock_raw,
    output logic locked,
    output logic lock_acq,
    output logic lock_lost
);

    localparam int               CNT_W    = $clog2(FILTER_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYC - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;

    // Synchroniser; held clear while the PLL is powered down so the
    // latency is seen again once power-up begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else if (!enable) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= lock_raw;
            sync_q2 <= sync_q1;
        end
    end

    // The edge that consumes the last required high sample declares lock.
    assign lock_acq  = enable && sync_q2 && !locked && (cnt == CNT_LAST);
    assign lock_lost = enable && locked && !sync_q2;

    // Consecutive-high counter; any low sample restarts it and drops lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            locked <= 1'b0;
        end else if (!enable || !sync_q2) begin
            cnt    <= '0;
            locked <= 1'b0;
        end else if (lock_acq) begin
            locked <= 1'b1;
        end else if (!locked) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pll_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pll_phase_ctrl
//  Description : Drives the dynamic phase-adjust and power-down pins of a
//                PolarFire CCC/PLL for up to four outputs. Powers the PLL up,
//                qualifies lock, runs multi-step rotate requests and tracks
//                each output's phase position modulo one period.
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_phase_ctrl
    import pll_phase_pkg::*;
#(
    parameter int NUM_OUT         = 4,
    parameter int PHASE_MOD       = 32,
    parameter int PHASE_CNT_W     = $clog2(PHASE_MOD),  // derived, leave at default
    parameter int PWRDN_CYC       = 16,
    parameter int LOCK_FILTER_CYC = 16,
    parameter int ROT_HI_CYC      = 2,
    parameter int ROT_LO_CYC      = 2,
    parameter int SETTLE_CYC      = 4
) (
    input  logic                           CLK,
    input  logic                           RESET_N,
    input  logic                           PLL_LOCK,
    input  logic                           REQ_VALID,
    output logic                           REQ_READY,
    input  logic [NUM_OUT-1:0]             REQ_SEL,
    input  logic                           REQ_DIR,
    input  logic [STEPS_W-1:0]             REQ_STEPS,
    input  logic                           ERR_CLR,
    output logic                           PLL_POWERDOWN_N,
    output logic [NUM_OUT-1:0]             PHASE_OUT_SEL,
    output logic                           PHASE_DIRECTION,
    output logic                           PHASE_ROTATE,
    output logic                           LOAD_PHASE_N,
    output logic [NUM_OUT*PHASE_CNT_W-1:0] PHASE_POS,
    output logic                           LOCKED,
    output logic                           BUSY,
    output logic                           DONE,
    output logic                           ERR
);

    localparam int               TMR_W       = 16;
    localparam logic [TMR_W-1:0] PWRDN_LAST  = TMR_W'(PWRDN_CYC - 1);
    localparam logic [TMR_W-1:0] ROT_HI_LAST = TMR_W'(ROT_HI_CYC - 1);
    localparam logic [TMR_W-1:0] ROT_LO_LAST = TMR_W'(ROT_LO_CYC - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);

    state_t               state,         state_nxt;
    logic [TMR_W-1:0]     tmr,           tmr_nxt;
    logic [STEPS_W-1:0]   steps_rem,     steps_nxt;
    logic [NUM_OUT-1:0]   sel_q,         sel_nxt;
    logic                 dir_q,         dir_nxt;
    logic                 pd_n_q,        pd_n_nxt;
    logic [NUM_OUT-1:0]   out_sel_q,     out_sel_nxt;
    logic                 direction_q,   direction_nxt;
    logic                 rotate_q,      rotate_nxt;
    logic                 load_n_q,      load_n_nxt;
    logic                 done_q,        done_nxt;
    logic                 err_q,         err_nxt;
    logic                 pos_step;
    logic                 pos_clear;

    logic                 filt_locked;
    logic                 lock_acq;
    logic                 lock_lost_raw;
    logic                 lock_lost;

    pll_lock_filter #(
        .FILTER_CYC (LOCK_FILTER_CYC)
    ) u_lock_filter (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .enable     (state != PWRDN),
        .lock_raw   (PLL_LOCK),
        .locked     (filt_locked),
        .lock_acq   (lock_acq),
        .lock_lost  (lock_lost_raw)
    );

    // Lock loss only matters once the sequencer has reached IDLE.
    assign lock_lost = lock_lost_raw && (state != PWRDN) && (state != WAIT_LOCK);

    // State and registered pin drivers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= PWRDN;
            tmr         <= '0;
            steps_rem   <= '0;
            sel_q       <= '0;
            dir_q       <= 1'b0;
            pd_n_q      <= 1'b0;
            out_sel_q   <= '0;
            direction_q <= 1'b0;
            rotate_q    <= 1'b0;
            load_n_q    <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_nxt;
            tmr         <= tmr_nxt;
            steps_rem   <= steps_nxt;
            sel_q       <= sel_nxt;
            dir_q       <= dir_nxt;
            pd_n_q      <= pd_n_nxt;
            out_sel_q   <= out_sel_nxt;
            direction_q <= direction_nxt;
            rotate_q    <= rotate_nxt;
            load_n_q    <= load_n_nxt;
            done_q      <= done_nxt;
            err_q       <= err_nxt;
        end
    end

    // Next state and next pin values; pins are decoded from the next state
    // so they change on the same edge the state does.
    always_comb begin
        state_nxt     = state;
        tmr_nxt       = tmr + 1'b1;
        steps_nxt     = steps_rem;
        sel_nxt       = sel_q;
        dir_nxt       = dir_q;
        pd_n_nxt      = pd_n_q;
        out_sel_nxt   = out_sel_q;
        direction_nxt = direction_q;
        rotate_nxt    = 1'b0;
        load_n_nxt    = 1'b1;
        done_nxt      = 1'b0;
        pos_step      = 1'b0;
        pos_clear     = 1'b0;

        case (state)
            PWRDN: begin
                if (tmr == PWRDN_LAST) begin
                    state_nxt = WAIT_LOCK;
                    tmr_nxt   = '0;
                    pd_n_nxt  = 1'b1;
                end
            end
            WAIT_LOCK: begin
                tmr_nxt = '0;
                if (lock_acq) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                tmr_nxt = '0;
                if (REQ_VALID) begin
                    sel_nxt   = REQ_SEL;
                    dir_nxt   = REQ_DIR;
                    steps_nxt = REQ_STEPS;
                    if ((REQ_STEPS == '0) || (REQ_SEL == '0)) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt     = SETUP;
                        out_sel_nxt   = REQ_SEL;
                        direction_nxt = REQ_DIR;
                    end
                end
            end
            SETUP: begin
                state_nxt  = ROT_HI;
                tmr_nxt    = '0;
                rotate_nxt = 1'b1;
            end
            ROT_HI: begin
                rotate_nxt = 1'b1;
                if (tmr == ROT_HI_LAST) begin
                    state_nxt  = ROT_LO;
                    tmr_nxt    = '0;
                    rotate_nxt = 1'b0;
                end
            end
            ROT_LO: begin
                if (tmr == ROT_LO_LAST) begin
                    tmr_nxt   = '0;
                    pos_step  = 1'b1;
                    steps_nxt = steps_rem - 1'b1;
                    if (steps_rem == STEPS_W'(1)) begin
                        state_nxt  = LOAD;
                        load_n_nxt = 1'b0;
                    end else begin
                        state_nxt  = ROT_HI;
                        rotate_nxt = 1'b1;
                    end
                end
            end
            LOAD: begin
                state_nxt   = SETTLE;
                tmr_nxt     = '0;
                out_sel_nxt = '0;
            end
            SETTLE: begin
                if (tmr == SETTLE_LAST) begin
                    state_nxt = IDLE;
                    tmr_nxt   = '0;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = PWRDN;
                tmr_nxt   = '0;
            end
        endcase

        // Lock loss aborts whatever is in flight and parks the pins safely.
        if (lock_lost) begin
            state_nxt   = WAIT_LOCK;
            tmr_nxt     = '0;
            rotate_nxt  = 1'b0;
            out_sel_nxt = '0;
            load_n_nxt  = 1'b1;
            done_nxt    = 1'b0;
            pos_step    = 1'b0;
            pos_clear   = 1'b1;
        end

        // Sticky error; a simultaneous loss outranks the clear.
        err_nxt = (err_q && !ERR_CLR) || lock_lost;
    end

    // Per-output phase position tracker.
    for (genvar i = 0; i < NUM_OUT; i++) begin : g_pos
        logic [PHASE_CNT_W-1:0] pos_q;

        // Step selected outputs at the end of each rotate; clear on lock loss.
        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                pos_q <= '0;
            end else if (pos_clear) begin
                pos_q <= '0;
            end else if (pos_step && sel_q[i]) begin
                pos_q <= PHASE_CNT_W'(phase_next(int'(pos_q), dir_q, PHASE_MOD));
            end
        end

        assign PHASE_POS[i*PHASE_CNT_W +: PHASE_CNT_W] = pos_q;
    end

    assign REQ_READY       = (state == IDLE);
    assign BUSY            = (state != IDLE);
    assign LOCKED          = filt_locked;
    assign PLL_POWERDOWN_N = pd_n_q;
    assign PHASE_OUT_SEL   = out_sel_q;
    assign PHASE_DIRECTION = direction_q;
    assign PHASE_ROTATE    = rotate_q;
    assign LOAD_PHASE_N    = load_n_q;
    assign DONE            = done_q;
    assign ERR             = err_q;

endmodule
`default_nettype wire
